imem_dmem_arbiter: RTL and testbench

- Arbitrates a single-port unified memory between the pipeline's instruction-fetch (IF) port and the data-memory (MEM) stage port.
- Serialises accesses through a three-state FSM and returns per-port done pulses and registered read data.
- Drives per-port stall signals into the pipeline's hazard logic.
- Data-side priority, bounded by a starvation guard so fetch always makes progress.

---
 rtl/cpu_mem_pkg.sv | 17 +
 rtl/imem_dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the instruction/data memory arbiter.
// State encoding, grant owners and default bus widths.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter between fetch and data-memory ports.
// Data side has priority, bounded by a starvation guard for fetch.
module imem_dmem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              flush,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nx;
    logic [3:0] starve_cnt;
    logic       drop;

    logic       if_elig;
    logic       d_elig;
    logic       gnt_valid;
    logic       gnt_owner;
    logic       fin_if;
    logic       fin_d;

    // A port finishing this cycle is masked so its held req cannot re-grant.
    assign if_elig = if_req & ~flush & ~if_done;
    assign d_elig  = d_req & ~d_done;

    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    // Next-state logic: arbitrate in IDLE, wait for mem_ready when busy.
    always_comb begin
        state_nx  = state;
        gnt_valid = 1'b0;
        gnt_owner = GNT_IF;
        fin_if    = 1'b0;
        fin_d     = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_elig && !(if_elig && starve_cnt == SMAX)) begin
                    gnt_valid = 1'b1;
                    gnt_owner = GNT_D;
                    state_nx  = D_BUSY;
                end else if (if_elig) begin
                    gnt_valid = 1'b1;
                    gnt_owner = GNT_IF;
                    state_nx  = I_BUSY;
                end
            end
            I_BUSY: begin
                if (mem_ready) begin
                    fin_if   = 1'b1;
                    state_nx = IDLE;
                end
            end
            D_BUSY: begin
                if (mem_ready) begin
                    fin_d    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Memory request latch, completion pulses, read data and drop flag.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            drop      <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            if (gnt_valid) begin
                mem_req <= 1'b1;
                if (gnt_owner == GNT_D) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end
            end
            if (fin_if || fin_d) begin
                mem_req <= 1'b0;
            end
            if (fin_if) begin
                // A flush on the completing edge discards the fetch as well.
                if (!(drop || flush)) begin
                    if_done  <= 1'b1;
                    if_rdata <= mem_rdata;
                end
                drop <= 1'b0;
            end else if (state == I_BUSY && flush) begin
                drop <= 1'b1;
            end
            if (fin_d) begin
                d_done <= 1'b1;
                if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    // Starvation counter: data grants that bypassed a waiting fetch.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            starve_cnt <= '0;
        end else if (!if_elig || (gnt_valid && gnt_owner == GNT_IF)) begin
            starve_cnt <= '0;
        end else if (gnt_valid && starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Randomized bench for imem_dmem_arbiter against a transaction model.
// Pipeline and memory behaviour are both randomized within protocol.
module tb_imem_dmem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int NCYC = 4000;

    localparam int OWN_NONE  = 0;
    localparam int OWN_FETCH = 1;
    localparam int OWN_DATA  = 2;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          if_stall;
    logic          flush;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    imem_dmem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .flush     (flush),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Model: one outstanding memory transaction plus visible port results.
    int        owner;
    bit        dropped;
    int        starve;
    bit        e_mem_req;
    bit        e_mem_we;
    bit [31:0] e_mem_addr;
    bit [31:0] e_mem_wdata;
    bit        e_if_done;
    bit        e_d_done;
    bit [31:0] e_if_rdata;
    bit [31:0] e_d_rdata;
    int        lat;
    int        n_if_done = 0;
    int        n_d_done  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        owner       = OWN_NONE;
        dropped     = 1'b0;
        starve      = 0;
        e_mem_req   = 1'b0;
        e_mem_we    = 1'b0;
        e_mem_addr  = '0;
        e_mem_wdata = '0;
        e_if_done   = 1'b0;
        e_d_done    = 1'b0;
        e_if_rdata  = '0;
        e_d_rdata   = '0;
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        bit fetch_ok;
        bit data_ok;
        bit take_data;
        bit take_fetch;
        if (Reset) begin
            model_reset();
            return;
        end
        fetch_ok   = if_req && !flush && !e_if_done;
        data_ok    = d_req && !e_d_done;
        take_data  = 1'b0;
        take_fetch = 1'b0;
        e_if_done  = 1'b0;
        e_d_done   = 1'b0;
        if (owner == OWN_NONE) begin
            if (data_ok && !(fetch_ok && starve == SMAX)) take_data = 1'b1;
            else if (fetch_ok) take_fetch = 1'b1;
            if (take_data) begin
                owner       = OWN_DATA;
                e_mem_req   = 1'b1;
                e_mem_we    = d_we;
                e_mem_addr  = d_addr;
                e_mem_wdata = d_wdata;
            end else if (take_fetch) begin
                owner       = OWN_FETCH;
                e_mem_req   = 1'b1;
                e_mem_we    = 1'b0;
                e_mem_addr  = if_addr;
                e_mem_wdata = '0;
            end
        end else if (owner == OWN_FETCH) begin
            if (flush) dropped = 1'b1;
            if (mem_ready) begin
                if (!dropped) begin
                    e_if_done  = 1'b1;
                    e_if_rdata = mem_rdata;
                end
                dropped   = 1'b0;
                owner     = OWN_NONE;
                e_mem_req = 1'b0;
            end
        end else begin
            if (mem_ready) begin
                e_d_done = 1'b1;
                if (!e_mem_we) e_d_rdata = mem_rdata;
                owner     = OWN_NONE;
                e_mem_req = 1'b0;
            end
        end
        if (!fetch_ok || take_fetch) starve = 0;
        else if (take_data && starve < SMAX) starve++;
    endtask

    task automatic check_outputs();
        check("mem_req", 32'(mem_req), 32'(e_mem_req));
        check("mem_we", 32'(mem_we), 32'(e_mem_we));
        check("mem_addr", mem_addr, e_mem_addr);
        check("mem_wdata", mem_wdata, e_mem_wdata);
        check("if_done", 32'(if_done), 32'(e_if_done));
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_done", 32'(d_done), 32'(e_d_done));
        check("d_rdata", d_rdata, e_d_rdata);
        check("done_overlap", 32'(if_done & d_done), 32'd0);
    endtask

    initial begin
        bit flush_prev;
        Reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        flush     = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        lat       = -1;
        flush_prev = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge CLK);
            check_outputs();
            if (e_if_done) n_if_done++;
            if (e_d_done) n_d_done++;

            Reset = (cyc < 2) || ($urandom_range(0, 199) == 0);

            if (!if_req || e_if_done || flush_prev) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = {$urandom_range(0, 255), 2'b00};
            end
            flush = ($urandom_range(0, 9) == 0);
            flush_prev = flush;

            if (!d_req || e_d_done) begin
                d_req   = ($urandom_range(0, 1) != 0);
                d_we    = ($urandom_range(0, 2) == 0);
                d_addr  = 32'h100 + {$urandom_range(0, 255), 2'b00};
                d_wdata = $urandom;
            end

            mem_rdata = $urandom;
            if (e_mem_req) begin
                if (lat < 0) lat = $urandom_range(0, 3);
                mem_ready = (lat == 0);
                lat--;
            end else begin
                lat       = -1;
                mem_ready = ($urandom_range(0, 15) == 0);
            end

            #1;
            check("if_stall", 32'(if_stall), 32'(if_req & ~e_if_done));
            check("d_stall", 32'(d_stall), 32'(d_req & ~e_d_done));
            model_step();
        end
        check("fetches_seen", 32'(n_if_done > 10), 32'd1);
        check("data_seen", 32'(n_d_done > 10), 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
